// File: rtl/pfd_pkg.sv
// Shared definitions for the phase-frequency detector / TDC and the loop filter
// that consumes its samples: state encoding, error sign convention and the
// saturation limit helper.
package pfd_pkg;

  localparam logic [1:0] STATE_IDLE = 2'd0;
  localparam logic [1:0] STATE_UP   = 2'd1;
  localparam logic [1:0] STATE_DOWN = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = STATE_IDLE,
    ST_UP   = STATE_UP,
    ST_DOWN = STATE_DOWN
  } pfd_state_e;

  // Positive error: ref edge arrived first. Negative error: fb edge arrived first.
  localparam int ERR_SIGN_REF_LEAD = 1;
  localparam int ERR_SIGN_FB_LEAD  = -1;

  // Largest magnitude a signed error word of width w may carry. The most
  // negative code is never produced so the word stays symmetric.
  function automatic int err_max(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

endpackage

// File: rtl/pfd_edge_sync.sv
// Multi-flop synchroniser for an asynchronous clock input followed by a
// single-cycle rising-edge detector on the two oldest stages.
module pfd_edge_sync #(
  parameter int SYNC_STAGES = 3
) (
  input  logic sys_clk,
  input  logic rst,
  input  logic async_in,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;

  // Shift the asynchronous input through the synchroniser chain.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
  end

  assign rise = (sync_q[SYNC_STAGES-1:SYNC_STAGES-2] == 2'b01);

endmodule

// File: rtl/pfd_tdc.sv
// Phase-frequency detector with time-to-digital output. Counts sys_clk cycles
// between ref and fb rising edges and issues a signed, strobed error sample.
// Optional lock detector is built only when PFD_TDC_LOCK_DET_EN is defined;
// otherwise locked is tied low.
//
//  state   | meaning
//  --------+-----------------------------------------------
//  ST_IDLE | waiting for the first edge of a pair
//  ST_UP   | ref edge seen, counting until fb edge
//  ST_DOWN | fb edge seen, counting until ref edge
module pfd_tdc
  import pfd_pkg::*;
#(
  parameter int SYNC_STAGES = 3,
  parameter int ERR_W       = 12,
  parameter int TIMEOUT     = 2047,
  parameter int LOCK_TOL    = 2,
  parameter int LOCK_COUNT  = 16
) (
  input  logic                    sys_clk,
  input  logic                    rst,
  input  logic                    ref_clk,
  input  logic                    fb_clk,
  input  logic                    enable,
  output logic signed [ERR_W-1:0] error_out,
  output logic                    err_valid,
  output logic                    up,
  output logic                    dn,
  output logic                    slip,
  output logic                    locked
);

  localparam int CW = ERR_W - 1;
  localparam logic signed [ERR_W-1:0] ERR_POS = ERR_W'(err_max(ERR_W));
  localparam logic signed [ERR_W-1:0] ERR_NEG = -ERR_POS;
  localparam logic [CW-1:0] CNT_MAX     = '1;
  localparam logic [CW-1:0] CNT_ONE     = CW'(1);
  localparam logic [CW-1:0] TIMEOUT_CNT = CW'(TIMEOUT);

  logic ref_rise, fb_rise;

  pfd_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ref_sync (
    .sys_clk  (sys_clk),
    .rst      (rst),
    .async_in (ref_clk),
    .rise     (ref_rise)
  );

  pfd_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_fb_sync (
    .sys_clk  (sys_clk),
    .rst      (rst),
    .async_in (fb_clk),
    .rise     (fb_rise)
  );

  pfd_state_e              state, state_nxt;
  logic [CW-1:0]           cnt, cnt_nxt;
  logic                    emit, slip_nxt;
  logic signed [ERR_W-1:0] emit_val;

  // State, counter and output registers; error_out holds between strobes.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      error_out <= '0;
      err_valid <= 1'b0;
      slip      <= 1'b0;
      up        <= 1'b0;
      dn        <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      err_valid <= emit;
      slip      <= slip_nxt;
      up        <= (state_nxt == ST_UP);
      dn        <= (state_nxt == ST_DOWN);
      if (emit) error_out <= emit_val;
    end
  end

  // Next-state, counter and sample generation. A repeated leading edge is a
  // cycle slip: the old measurement is reported saturated and the new edge
  // restarts the count in the same direction.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    emit      = 1'b0;
    emit_val  = '0;
    slip_nxt  = 1'b0;
    if (!enable) begin
      state_nxt = ST_IDLE;
      cnt_nxt   = '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (ref_rise && fb_rise) begin
            emit     = 1'b1;
            emit_val = '0;
          end else if (ref_rise) begin
            state_nxt = ST_UP;
            cnt_nxt   = CNT_ONE;
          end else if (fb_rise) begin
            state_nxt = ST_DOWN;
            cnt_nxt   = CNT_ONE;
          end
        end
        ST_UP: begin
          if (fb_rise) begin
            emit      = 1'b1;
            emit_val  = $signed({1'b0, cnt});
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
          end else if (ref_rise) begin
            emit     = 1'b1;
            emit_val = ERR_POS;
            slip_nxt = 1'b1;
            cnt_nxt  = CNT_ONE;
          end else if (cnt == TIMEOUT_CNT) begin
            emit      = 1'b1;
            emit_val  = ERR_POS;
            slip_nxt  = 1'b1;
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
          end else if (cnt != CNT_MAX) begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
        ST_DOWN: begin
          if (ref_rise) begin
            emit      = 1'b1;
            emit_val  = -$signed({1'b0, cnt});
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
          end else if (fb_rise) begin
            emit     = 1'b1;
            emit_val = ERR_NEG;
            slip_nxt = 1'b1;
            cnt_nxt  = CNT_ONE;
          end else if (cnt == TIMEOUT_CNT) begin
            emit      = 1'b1;
            emit_val  = ERR_NEG;
            slip_nxt  = 1'b1;
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
          end else if (cnt != CNT_MAX) begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
        default: begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

`ifdef PFD_TDC_LOCK_DET_EN
  localparam int LCW = $clog2(LOCK_COUNT + 1);
  localparam logic [LCW-1:0]   LOCK_TARGET = LCW'(LOCK_COUNT);
  localparam logic [ERR_W-1:0] LOCK_TOL_W  = ERR_W'(LOCK_TOL);

  logic [LCW-1:0]   lock_cnt, lock_cnt_nxt;
  logic [ERR_W-1:0] err_mag;

  assign err_mag = error_out[ERR_W-1] ? ERR_W'(-error_out) : ERR_W'(error_out);

  // Run length of consecutive good samples, judged on the registered strobe.
  always_comb begin
    lock_cnt_nxt = lock_cnt;
    if (!enable) begin
      lock_cnt_nxt = '0;
    end else if (err_valid) begin
      if (!slip && (err_mag <= LOCK_TOL_W)) begin
        if (lock_cnt != LOCK_TARGET) lock_cnt_nxt = lock_cnt + LCW'(1);
      end else begin
        lock_cnt_nxt = '0;
      end
    end
  end

  // Lock counter and indicator; locked follows the counter reaching target.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      lock_cnt <= '0;
      locked   <= 1'b0;
    end else begin
      lock_cnt <= lock_cnt_nxt;
      locked   <= (lock_cnt_nxt == LOCK_TARGET);
    end
  end
`else
  assign locked = 1'b0;
`endif

endmodule

// File: tb/tb_pfd_tdc.sv
// Self-checking bench for pfd_tdc. Edges are placed on known sys_clk cycles so
// the expected error is the programmed distance; lock expectations follow a
// run-length model and depend on PFD_TDC_LOCK_DET_EN.
module tb_pfd_tdc;

  localparam int SYNC    = 3;
  localparam int ERR_MAX = 2047;
  localparam int TMO     = 2047;
  localparam int TMO_S   = 30;
  localparam int LTOL    = 2;
  localparam int LCOUNT  = 16;
`ifdef PFD_TDC_LOCK_DET_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic sys_clk = 1'b0;
  logic rst = 1'b1;
  logic ref_clk = 1'b0;
  logic fb_clk = 1'b0;
  logic enable = 1'b1;

  logic signed [11:0] err0, err1;
  logic ev0, up0, dn0, slip0, lk0;
  logic ev1, up1, dn1, slip1, lk1;

  pfd_tdc dut (
    .sys_clk(sys_clk), .rst(rst), .ref_clk(ref_clk), .fb_clk(fb_clk), .enable(enable),
    .error_out(err0), .err_valid(ev0), .up(up0), .dn(dn0), .slip(slip0), .locked(lk0)
  );

  pfd_tdc #(.TIMEOUT(TMO_S)) dut_to (
    .sys_clk(sys_clk), .rst(rst), .ref_clk(ref_clk), .fb_clk(fb_clk), .enable(enable),
    .error_out(err1), .err_valid(ev1), .up(up1), .dn(dn1), .slip(slip1), .locked(lk1)
  );

  always #5 sys_clk = ~sys_clk;

  int vectors = 0;
  int miscompares = 0;

  int n_strobe = 0, n_strobe_to = 0;
  int err_log[0:511], slip_log[0:511], lk_at[0:511], lk_after[0:511];
  int to_err_log[0:63], to_slip_log[0:63];
  int up_total = 0, dn_total = 0, overlap_total = 0;
  bit pend = 1'b0;

  // Strobe logger and up/dn pulse counters, sampled mid-cycle.
  always @(negedge sys_clk) begin
    if (pend && n_strobe > 0) lk_after[n_strobe-1] = int'(lk0);
    pend = 1'b0;
    if (ev0 && n_strobe < 512) begin
      err_log[n_strobe]  = int'(err0);
      slip_log[n_strobe] = int'(slip0);
      lk_at[n_strobe]    = int'(lk0);
      n_strobe++;
      pend = 1'b1;
    end
    if (ev1 && n_strobe_to < 64) begin
      to_err_log[n_strobe_to]  = int'(err1);
      to_slip_log[n_strobe_to] = int'(slip1);
      n_strobe_to++;
    end
    if (up0) up_total++;
    if (dn0) dn_total++;
    if (up0 && dn0) overlap_total++;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int good_run = 0;

  task automatic check(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #2;
    end
  endtask

  // Reference: signed edge distance, saturated with slip once it exceeds the timeout.
  function automatic int model_err(input int d, input int tmo);
    if (d > tmo)  return ERR_MAX;
    if (-d > tmo) return -ERR_MAX;
    return d;
  endfunction

  function automatic int model_good(input int e);
    return ((e <= LTOL) && (e >= -LTOL)) ? 1 : 0;
  endfunction

  task automatic check_quiet(input string tag);
    check({tag, " error_out"}, int'(err0), 0);
    check({tag, " err_valid"}, int'(ev0), 0);
    check({tag, " up"}, int'(up0), 0);
    check({tag, " dn"}, int'(dn0), 0);
    check({tag, " slip"}, int'(slip0), 0);
    check({tag, " locked"}, int'(lk0), 0);
  endtask

  // Drive one ref/fb pair d cycles apart (d>0 ref first) and check the sample.
  task automatic send_pair(input int d, input string tag);
    int s0, u0, n0, lat, exp_e, prev;
    s0 = n_strobe;
    u0 = up_total;
    n0 = dn_total;
    if (d == 0) begin
      ref_clk = 1'b1;
      fb_clk  = 1'b1;
    end else if (d > 0) begin
      ref_clk = 1'b1;
      cyc(d);
      fb_clk = 1'b1;
    end else begin
      fb_clk = 1'b1;
      cyc(-d);
      ref_clk = 1'b1;
    end
    lat = 0;
    while (n_strobe == s0 && lat < 20) begin
      @(negedge sys_clk);
      #1;
      lat++;
    end
    check({tag, " latency_ok"}, int'(lat >= SYNC && lat <= SYNC + 2), 1);
    @(posedge sys_clk);
    #2;
    cyc(2);
    ref_clk = 1'b0;
    fb_clk  = 1'b0;
    cyc(10);
    exp_e = model_err(d, TMO);
    check({tag, " strobes"}, n_strobe - s0, 1);
    if (n_strobe > s0) begin
      check({tag, " error"}, err_log[s0], exp_e);
      check({tag, " slip"}, slip_log[s0], 0);
      prev = good_run;
      good_run = model_good(exp_e) ? good_run + 1 : 0;
      check({tag, " locked_at_strobe"}, lk_at[s0], int'(LOCK_EN && prev >= LCOUNT));
      check({tag, " locked_after"}, lk_after[s0], int'(LOCK_EN && good_run >= LCOUNT));
    end
    check({tag, " up_cycles"}, up_total - u0, (d > 0) ? d : 0);
    check({tag, " dn_cycles"}, dn_total - n0, (d < 0) ? -d : 0);
  endtask

  initial begin
    int s0, t0, w, d;

    // Reset state
    cyc(1);
    check_quiet("reset");
    check("reset dut_to idle", int'({up1, dn1, ev1, slip1, lk1}), 0);
    check("reset dut_to error", int'(err1), 0);
    cyc(2);
    rst = 1'b0;
    cyc(4);
    check_quiet("post_reset");

    // Directed pairs: ref leads 5, fb leads 7, coincident edges
    send_pair(5, "ref_lead5");
    send_pair(-7, "fb_lead7");
    send_pair(0, "coincident");

    // Cycle slip on main instance, timeout on the short-timeout instance
    enable = 1'b0;
    cyc(2);
    enable = 1'b1;
    cyc(2);
    good_run = 0;
    s0 = n_strobe;
    t0 = n_strobe_to;
    ref_clk = 1'b1;
    cyc(3);
    ref_clk = 1'b0;
    cyc(32);
    check("timeout dut_to back_to_idle", int'(up1), 0);
    check("slip main still_up", int'(up0), 1);
    cyc(5);
    ref_clk = 1'b1;
    cyc(3);
    ref_clk = 1'b0;
    cyc(2);
    fb_clk = 1'b1;
    cyc(3);
    fb_clk = 1'b0;
    cyc(12);
    check("slip strobes", n_strobe - s0, 2);
    check("slip value", err_log[s0], ERR_MAX);
    check("slip flag", slip_log[s0], 1);
    check("after_slip value", err_log[s0+1], 5);
    check("after_slip flag", slip_log[s0+1], 0);
    check("timeout strobes", n_strobe_to - t0, 2);
    check("timeout value", to_err_log[t0], model_err(40, TMO_S));
    check("timeout flag", to_slip_log[t0], 1);
    check("timeout next value", to_err_log[t0+1], 5);

    // Reset three cycles into UP discards the measurement
    s0 = n_strobe;
    ref_clk = 1'b1;
    w = 0;
    while (!up0 && w < 20) begin
      cyc(1);
      w++;
    end
    check("rst_mid enter_up", int'(up0), 1);
    cyc(3);
    rst = 1'b1;
    cyc(1);
    ref_clk = 1'b0;
    check_quiet("rst_mid");
    cyc(2);
    rst = 1'b0;
    good_run = 0;
    cyc(10);
    check("rst_mid no_strobe", n_strobe - s0, 0);
    check("rst_mid up_low", int'(up0), 0);

    // Dropping enable mid-DOWN discards the measurement
    s0 = n_strobe;
    fb_clk = 1'b1;
    w = 0;
    while (!dn0 && w < 20) begin
      cyc(1);
      w++;
    end
    check("en_drop enter_dn", int'(dn0), 1);
    cyc(2);
    enable = 1'b0;
    cyc(2);
    check("en_drop dn_low", int'(dn0), 0);
    check("en_drop up_low", int'(up0), 0);
    fb_clk = 1'b0;
    cyc(6);
    enable = 1'b1;
    good_run = 0;
    cyc(3);
    check("en_drop no_strobe", n_strobe - s0, 0);
    send_pair(4, "after_en_drop");

    // Lock run: 16 good samples then one outside tolerance
    send_pair(5, "lock_clear");
    for (int k = 1; k <= LCOUNT; k++) send_pair(1, "lock_run");
    check("lock asserted", int'(lk0), int'(LOCK_EN));
    send_pair(5, "lock_break");
    check("lock dropped", int'(lk0), 0);

    // Randomised pair distances
    for (int k = 0; k < 20; k++) begin
      d = int'($urandom_range(120)) - 60;
      send_pair(d, "random");
    end

    check("up_dn never overlap", overlap_total, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
